func_iter_core: RTL

//  Multi-cycle arithmetic responder on the func start/busy handshake; func_unit is the initiator.

---
 rtl/func_iter_core_pkg.sv | 21 ++
 rtl/func_iter_core_if.sv | 35 +++
 rtl/func_iter_core_isqrt_step.sv | 39 +++
 rtl/func_iter_core.sv | 125 ++++++++++++
 4 files changed

// File: rtl/func_iter_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : func_iter_core_pkg                                        |
// | Purpose  : Shared state encodings and default width for the          |
// |            func_iter_core arithmetic responder.                      |
// | Contents : FUNC_WIDTH default, func_state_e (2-bit FSM states)       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package func_iter_core_pkg;

    localparam int FUNC_WIDTH = 32;

    typedef enum logic [1:0] {
        FUNC_ST_IDLE = 2'd0,
        FUNC_ST_MUL  = 2'd1,
        FUNC_ST_SQRT = 2'd2,
        FUNC_ST_ADD  = 2'd3
    } func_state_e;

endpackage
`default_nettype wire

// File: rtl/func_iter_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : func_iter_core_if                                         |
// | Purpose  : start/busy handshake between func_unit (master) and the   |
// |            iterative arithmetic core (slave).                        |
// | Signals  : start_i  request pulse          (master -> slave)         |
// |            a_bi     operand a, WIDTH bits  (master -> slave)         |
// |            b_bi     operand b, WIDTH bits  (master -> slave)         |
// |            busy_o   job in progress        (slave -> master)         |
// |            y_bo     result, WIDTH bits     (slave -> master)         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface func_iter_core_if
    import func_iter_core_pkg::*;
#(
    parameter int WIDTH = FUNC_WIDTH
);
    logic             start_i;
    logic [WIDTH-1:0] a_bi;
    logic [WIDTH-1:0] b_bi;
    logic             busy_o;
    logic [WIDTH-1:0] y_bo;

    modport master (
        output start_i, a_bi, b_bi,
        input  busy_o, y_bo
    );

    modport slave (
        input  start_i, a_bi, b_bi,
        output busy_o, y_bo
    );

endinterface
`default_nettype wire

// File: rtl/func_iter_core_isqrt_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : func_isqrt_step                                           |
// | Purpose  : One combinational iteration of the digit-by-digit integer |
// |            square root (one result bit per call).                    |
// | Ports    : x   in  remaining radicand     x_n out  next remainder    |
// |            r   in  partial root           r_n out  next root         |
// |            m   in  current bit mask       m_n out  next mask (m>>2)  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module func_isqrt_step
    import func_iter_core_pkg::*;
#(
    parameter int WIDTH = FUNC_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] x_n,
    output logic [WIDTH-1:0] r_n,
    output logic [WIDTH-1:0] m_n
);

    logic [WIDTH-1:0] trial;

    always_comb begin
        trial = r | m;
        x_n   = x;
        r_n   = r >> 1;
        m_n   = m >> 2;
        // Subtract only when it fits, so x can never underflow.
        if (x >= trial) begin
            x_n = x - trial;
            r_n = (r >> 1) | m;
        end
    end

endmodule
`default_nettype wire

// File: rtl/func_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : func_iter_core                                            |
// | Purpose  : Multi-cycle responder computing                           |
// |            y = (a*a mod 2^WIDTH) + floor(sqrt(b))                    |
// |            with a shift-add squarer followed by an iterative root.   |
// | Ports    : clk    in  clock, rising edge                             |
// |            rst_n  in  asynchronous active-low reset                  |
// |            bus    slave side of func_iter_core_if                    |
// |                   (start_i, a_bi, b_bi in / busy_o, y_bo out)        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module func_iter_core
    import func_iter_core_pkg::*;
#(
    parameter int WIDTH = FUNC_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    func_iter_core_if.slave   bus
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(WIDTH / 2 - 1);
    localparam logic [WIDTH-1:0] M_INIT    = WIDTH'(1) << (WIDTH - 2);

    func_state_e      state;
    logic [CNT_W-1:0] cnt;      // shared by the MUL and SQRT phases
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] sq_x;
    logic [WIDTH-1:0] sq_r;
    logic [WIDTH-1:0] sq_m;
    logic             busy;
    logic [WIDTH-1:0] y;

    logic [WIDTH-1:0] sq_x_n;
    logic [WIDTH-1:0] sq_r_n;
    logic [WIDTH-1:0] sq_m_n;

    func_isqrt_step #(
        .WIDTH (WIDTH)
    ) u_isqrt_step (
        .x   (sq_x),
        .r   (sq_r),
        .m   (sq_m),
        .x_n (sq_x_n),
        .r_n (sq_r_n),
        .m_n (sq_m_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FUNC_ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            a_sh  <= '0;
            sq_x  <= '0;
            sq_r  <= '0;
            sq_m  <= '0;
            busy  <= 1'b0;
            y     <= '0;
        end else begin
            case (state)
                FUNC_ST_IDLE: begin
                    // busy is low exactly while in IDLE, so a start seen
                    // during a job never reaches this branch.
                    if (bus.start_i) begin
                        acc   <= '0;
                        mcand <= bus.a_bi;
                        a_sh  <= bus.a_bi;
                        sq_x  <= bus.b_bi;
                        sq_r  <= '0;
                        sq_m  <= M_INIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= FUNC_ST_MUL;
                    end
                end
                FUNC_ST_MUL: begin
                    // No early exit on a zero multiplier: fixed latency.
                    if (a_sh[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    a_sh  <= a_sh >> 1;
                    if (cnt == MUL_LAST) begin
                        cnt   <= '0;
                        state <= FUNC_ST_SQRT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FUNC_ST_SQRT: begin
                    sq_x <= sq_x_n;
                    sq_r <= sq_r_n;
                    sq_m <= sq_m_n;
                    if (cnt == SQRT_LAST) begin
                        cnt   <= '0;
                        state <= FUNC_ST_ADD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FUNC_ST_ADD: begin
                    y     <= acc + sq_r;
                    busy  <= 1'b0;
                    state <= FUNC_ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= FUNC_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o = busy;
    assign bus.y_bo   = y;

endmodule
`default_nettype wire
